fme_arbiter: RTL and testbench

FME_ARBITER -- requirements
Module: fme_arbiter

---
 rtl/rsa_pkg.sv | 7 +
 rtl/fme_req_slot.sv | 51 +++++
 rtl/fme_arbiter.sv | 123 ++++++++++++
 tb/tb_fme_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width default, FSM state type and requester indices for the FME arbiter.
package rsa_pkg;
  localparam int WIDTH_DEFAULT = 32;
  localparam int ENC = 0;
  localparam int DEC = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
endpackage

// File: rtl/fme_req_slot.sv
// fme_req_slot: per-requester operand latch, busy flag and result register.
module fme_req_slot
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_mod,
  input  logic             i_res_we,
  input  logic [WIDTH-1:0] i_res,
  input  logic             i_clr,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_base,
  output logic [WIDTH-1:0] o_exp,
  output logic [WIDTH-1:0] o_mod,
  output logic [WIDTH-1:0] o_result
);
  logic             r_busy;
  logic [WIDTH-1:0] r_base, r_exp, r_mod, r_result;

  // a start while busy (including the done cycle) never touches the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_base   <= '0;
      r_exp    <= '0;
      r_mod    <= '0;
      r_result <= '0;
    end else begin
      if (i_start && !r_busy) begin
        r_busy <= 1'b1;
        r_base <= i_base;
        r_exp  <= i_exp;
        r_mod  <= i_mod;
      end else if (i_clr) begin
        r_busy <= 1'b0;
      end
      if (i_res_we) r_result <= i_res;
    end
  end

  assign o_busy   = r_busy;
  assign o_base   = r_base;
  assign o_exp    = r_exp;
  assign o_mod    = r_mod;
  assign o_result = r_result;
endmodule

// File: rtl/fme_arbiter.sv
// fme_arbiter: round-robin arbiter sharing one FME unit between encrypter and decrypter.
module fme_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_start,
  input  logic [WIDTH-1:0] enc_base,
  input  logic [WIDTH-1:0] enc_exp,
  input  logic [WIDTH-1:0] enc_mod,
  input  logic             dec_start,
  input  logic [WIDTH-1:0] dec_base,
  input  logic [WIDTH-1:0] dec_exp,
  input  logic [WIDTH-1:0] dec_mod,
  output logic             enc_busy,
  output logic             dec_busy,
  output logic             enc_done,
  output logic             dec_done,
  output logic             enc_err,
  output logic             dec_err,
  output logic [WIDTH-1:0] enc_result,
  output logic [WIDTH-1:0] dec_result,
  output logic             fme_start,
  output logic [WIDTH-1:0] fme_base,
  output logic [WIDTH-1:0] fme_exp,
  output logic [WIDTH-1:0] fme_mod,
  input  logic             fme_done,
  input  logic [WIDTH-1:0] fme_result
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  state_t           r_state;
  logic             r_gnt, r_last, r_fme_start;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_done, r_err;
  logic [1:0]       w_busy, w_res_we, w_clr;
  logic [WIDTH-1:0] w_base [2];
  logic [WIDTH-1:0] w_exp [2];
  logic [WIDTH-1:0] w_mod [2];
  logic [WIDTH-1:0] w_result [2];
  logic [WIDTH-1:0] w_res;
  logic             w_gnt, w_hit, w_to, w_act;

  assign w_gnt    = &w_busy ? ~r_last : w_busy[DEC];
  assign w_hit    = (r_state == WAIT) && fme_done;
  assign w_to     = (r_state == WAIT) && !fme_done && (r_cnt == CW'(TIMEOUT - 1));
  assign w_res    = w_hit ? fme_result : '0;
  assign w_res_we = (w_hit || w_to) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr    = (r_state == DELIVER) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign w_act    = r_state != IDLE;

  fme_req_slot #(.WIDTH(WIDTH)) u_enc (
    .clk(clk), .rst_n(rst_n), .i_start(enc_start),
    .i_base(enc_base), .i_exp(enc_exp), .i_mod(enc_mod),
    .i_res_we(w_res_we[ENC]), .i_res(w_res), .i_clr(w_clr[ENC]),
    .o_busy(w_busy[ENC]), .o_base(w_base[ENC]), .o_exp(w_exp[ENC]),
    .o_mod(w_mod[ENC]), .o_result(w_result[ENC])
  );

  fme_req_slot #(.WIDTH(WIDTH)) u_dec (
    .clk(clk), .rst_n(rst_n), .i_start(dec_start),
    .i_base(dec_base), .i_exp(dec_exp), .i_mod(dec_mod),
    .i_res_we(w_res_we[DEC]), .i_res(w_res), .i_clr(w_clr[DEC]),
    .o_busy(w_busy[DEC]), .o_base(w_base[DEC]), .o_exp(w_exp[DEC]),
    .o_mod(w_mod[DEC]), .o_result(w_result[DEC])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_last      <= 1'(DEC);
      r_cnt       <= '0;
      r_fme_start <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
    end else begin
      r_fme_start <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      case (r_state)
        IDLE: if (|w_busy) begin
          r_gnt       <= w_gnt;
          r_fme_start <= 1'b1;
          r_state     <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (w_hit || w_to) begin
          r_done[r_gnt] <= 1'b1;
          r_err[r_gnt]  <= w_to;
          r_state       <= DELIVER;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        DELIVER: begin
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // operands come straight from the granted slot, so they stay stable until IDLE
  assign fme_start  = r_fme_start;
  assign fme_base   = w_act ? w_base[r_gnt] : '0;
  assign fme_exp    = w_act ? w_exp[r_gnt] : '0;
  assign fme_mod    = w_act ? w_mod[r_gnt] : '0;
  assign enc_busy   = w_busy[ENC];
  assign dec_busy   = w_busy[DEC];
  assign enc_done   = r_done[ENC];
  assign dec_done   = r_done[DEC];
  assign enc_err    = r_err[ENC];
  assign dec_err    = r_err[DEC];
  assign enc_result = w_result[ENC];
  assign dec_result = w_result[DEC];
endmodule

// File: tb/tb_fme_arbiter.sv
// tb_fme_arbiter: scoreboard bench for fme_arbiter with a behavioural FME model.
module tb_fme_arbiter;
  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0, rst_n = 1'b1;
  logic         enc_start = 1'b0, dec_start = 1'b0;
  logic [W-1:0] enc_base = '0, enc_exp = '0, enc_mod = '0;
  logic [W-1:0] dec_base = '0, dec_exp = '0, dec_mod = '0;
  logic         enc_busy, dec_busy, enc_done, dec_done, enc_err, dec_err;
  logic [W-1:0] enc_result, dec_result;
  logic         fme_start, fme_done;
  logic [W-1:0] fme_base, fme_exp, fme_mod, fme_result;
  logic         m_done = 1'b0, stray = 1'b0;
  logic [W-1:0] m_res = '0;
  int           fme_lat = 10;
  bit           fme_mute = 1'b0;
  int           vectors = 0, errors = 0;

  typedef struct {
    bit           who;
    logic [W-1:0] b, e, m, r;
    bit           err;
  } txn_t;
  txn_t q[$];
  txn_t mt;

  assign fme_done   = m_done | stray;
  assign fme_result = m_res;

  always #5 clk = ~clk;

  fme_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_start(enc_start), .enc_base(enc_base), .enc_exp(enc_exp), .enc_mod(enc_mod),
    .dec_start(dec_start), .dec_base(dec_base), .dec_exp(dec_exp), .dec_mod(dec_mod),
    .enc_busy(enc_busy), .dec_busy(dec_busy), .enc_done(enc_done), .dec_done(dec_done),
    .enc_err(enc_err), .dec_err(dec_err), .enc_result(enc_result), .dec_result(dec_result),
    .fme_start(fme_start), .fme_base(fme_base), .fme_exp(fme_exp), .fme_mod(fme_mod),
    .fme_done(fme_done), .fme_result(fme_result)
  );

  function automatic logic [W-1:0] fme_f(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    logic [63:0] acc, sq, mm;
    if (m == '0) return b ^ e;
    mm  = {32'd0, m};
    acc = 64'd1 % mm;
    sq  = {32'd0, b} % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) acc = (acc * sq) % mm;
      sq = (sq * sq) % mm;
    end
    return acc[W-1:0];
  endfunction

  always @(negedge clk) begin
    if (fme_start && !fme_mute) begin
      repeat (fme_lat) @(negedge clk);
      m_res  = fme_f(fme_base, fme_exp, fme_mod);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fme_start) begin
        vectors++;
        if (q.size() == 0 || {fme_base, fme_exp, fme_mod} !== {q[0].b, q[0].e, q[0].m}) begin
          errors++;
          $display("FAIL fme_ops got=%0h/%0h/%0h pending=%0d", fme_base, fme_exp, fme_mod, q.size());
        end
      end
      if (enc_done || dec_done) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done enc=%b dec=%b required=none", enc_done, dec_done);
        end else begin
          mt = q.pop_front();
          if ({dec_done, enc_done} !== (mt.who ? 2'b10 : 2'b01) ||
              (mt.who ? dec_result : enc_result) !== mt.r ||
              {dec_err, enc_err} !== (mt.err ? (mt.who ? 2'b10 : 2'b01) : 2'b00) ||
              {fme_base, fme_exp, fme_mod} !== {mt.b, mt.e, mt.m}) begin
            errors++;
            $display("FAIL done done=%b%b err=%b%b res=%0h ops=%0h/%0h/%0h exp who=%0d res=%0h err=%0d ops=%0h/%0h/%0h",
                     dec_done, enc_done, dec_err, enc_err, mt.who ? dec_result : enc_result,
                     fme_base, fme_exp, fme_mod, mt.who, mt.r, mt.err, mt.b, mt.e, mt.m);
          end
        end
      end
    end
  end

  task automatic go(input bit e, input bit d, input logic [W-1:0] eb, input logic [W-1:0] ee,
                    input logic [W-1:0] em, input logic [W-1:0] db, input logic [W-1:0] de,
                    input logic [W-1:0] dm);
    @(negedge clk);
    enc_start = e; enc_base = eb; enc_exp = ee; enc_mod = em;
    dec_start = d; dec_base = db; dec_exp = de; dec_mod = dm;
    @(negedge clk);
    enc_start = 1'b0;
    dec_start = 1'b0;
  endtask

  task automatic drain(input int budget, output int left);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    left = q.size();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({enc_busy, dec_busy, enc_done, dec_done, enc_err, dec_err, fme_start} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {enc_busy, dec_busy, enc_done, dec_done, enc_err, dec_err, fme_start});
    end
    vectors++;
    if ({fme_base, fme_exp, fme_mod} !== '0) begin
      errors++;
      $display("FAIL reset_fme_ops got=%0h/%0h/%0h exp=0", fme_base, fme_exp, fme_mod);
    end
    vectors++;
    if ({enc_result, dec_result} !== '0) begin
      errors++;
      $display("FAIL reset_results got=%0h/%0h exp=0", enc_result, dec_result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({fme_start, enc_busy, dec_busy} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=000", {fme_start, enc_busy, dec_busy});
    end
  endtask

  task automatic test_single();
    int left;
    q.push_back('{1'b0, 32'd5, 32'd3, 32'd33, 32'd26, 1'b0});
    go(1'b1, 1'b0, 5, 3, 33, 0, 0, 0);
    vectors++;
    if ({enc_busy, fme_start} !== 2'b10) begin
      errors++;
      $display("FAIL single_lat1 busy,start got=%b exp=10", {enc_busy, fme_start});
    end
    @(negedge clk);
    vectors++;
    if ({fme_start, fme_base, fme_exp, fme_mod} !== {1'b1, 32'd5, 32'd3, 32'd33}) begin
      errors++;
      $display("FAIL single_lat2 start=%b ops=%0d/%0d/%0d exp start=1 ops=5/3/33", fme_start, fme_base, fme_exp, fme_mod);
    end
    drain(40, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL single_drain pending=%0d exp=0", left);
    end
    @(negedge clk);
    vectors++;
    if ({enc_result, enc_busy, dec_busy, dec_done, dec_err, dec_result} !== {32'd26, 4'b0, 32'd0}) begin
      errors++;
      $display("FAIL single_hold enc_res=%0d enc_busy=%b dec=%b%b%b dec_res=%0h exp 26,0,000,0",
               enc_result, enc_busy, dec_busy, dec_done, dec_err, dec_result);
    end
  endtask

  task automatic test_tie();
    int left;
    reset_dut();
    q.push_back('{1'b0, 32'd2, 32'd3, 32'd5, 32'd3, 1'b0});
    q.push_back('{1'b1, 32'd3, 32'd3, 32'd7, 32'd6, 1'b0});
    go(1'b1, 1'b1, 2, 3, 5, 3, 3, 7);
    drain(80, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL tie1_drain pending=%0d exp=0", left);
    end
    q.push_back('{1'b0, 32'd4, 32'd2, 32'd9, 32'd7, 1'b0});
    go(1'b1, 1'b0, 4, 2, 9, 0, 0, 0);
    drain(40, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL tie_solo_drain pending=%0d exp=0", left);
    end
    // enc was granted last, so this tie belongs to dec
    q.push_back('{1'b1, 32'd6, 32'd2, 32'd11, 32'd3, 1'b0});
    q.push_back('{1'b0, 32'd5, 32'd2, 32'd7, 32'd4, 1'b0});
    go(1'b1, 1'b1, 5, 2, 7, 6, 2, 11);
    drain(80, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL tie2_drain pending=%0d exp=0", left);
    end
  endtask

  task automatic test_back_to_back();
    int n, left;
    q.push_back('{1'b0, 32'd7, 32'd2, 32'd10, 32'd9, 1'b0});
    q.push_back('{1'b1, 32'd2, 32'd10, 32'd1000, 32'd24, 1'b0});
    go(1'b1, 1'b0, 7, 2, 10, 0, 0, 0);
    repeat (3) @(negedge clk);
    go(1'b0, 1'b1, 0, 0, 0, 2, 10, 1000);
    n = 0;
    while (!enc_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (enc_done !== 1'b1 || dec_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first enc_done=%b dec_busy=%b exp 1,1", enc_done, dec_busy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({fme_start, fme_base} !== {1'b1, 32'd2}) begin
      errors++;
      $display("FAIL b2b_next start=%b base=%0d exp start=1 base=2", fme_start, fme_base);
    end
    drain(40, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL b2b_drain pending=%0d exp=0", left);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    q.push_back('{1'b0, 32'd11, 32'd7, 32'd13, 32'd2, 1'b0});
    go(1'b1, 1'b0, 11, 7, 13, 0, 0, 0);
    repeat (3) @(negedge clk);
    go(1'b1, 1'b0, 99, 98, 97, 0, 0, 0);
    n = 0;
    while (!enc_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (enc_done !== 1'b1) begin
      errors++;
      $display("FAIL busy_done got=%b exp=1", enc_done);
    end
    enc_start = 1'b1; enc_base = 55; enc_exp = 56; enc_mod = 57;
    @(negedge clk);
    enc_start = 1'b0;
    vectors++;
    if (enc_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_same_cycle_start enc_busy=%b exp=0", enc_busy);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if ({enc_result, enc_busy, fme_start} !== {32'd2, 2'b00}) begin
      errors++;
      $display("FAIL busy_single_done res=%0d busy=%b start=%b exp 2,0,0", enc_result, enc_busy, fme_start);
    end
  endtask

  task automatic test_mod_zero();
    int left;
    q.push_back('{1'b1, 32'h1234, 32'h00FF, 32'd0, 32'h12CB, 1'b0});
    go(1'b0, 1'b1, 0, 0, 0, 32'h1234, 32'h00FF, 0);
    drain(40, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL modzero_drain pending=%0d exp=0", left);
    end
  endtask

  task automatic test_timeout();
    int n, k;
    fme_mute = 1'b1;
    q.push_back('{1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1});
    go(1'b1, 1'b0, 3, 4, 0, 0, 0, 0);
    n = 0;
    while (!fme_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (!enc_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k !== TO + 1 || fme_start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_latency got=%0d exp=%0d", k, TO + 1);
    end
    @(negedge clk);
    vectors++;
    if ({fme_start, enc_busy, fme_base, fme_exp, fme_mod, enc_err} !== '0) begin
      errors++;
      $display("FAIL timeout_idle start=%b busy=%b ops=%0h/%0h/%0h err=%b exp 0", fme_start, enc_busy,
               fme_base, fme_exp, fme_mod, enc_err);
    end
    fme_mute = 1'b0;
  endtask

  task automatic test_reset_wait();
    int left;
    bit seen;
    fme_mute = 1'b1;
    q.push_back('{1'b0, 32'd8, 32'd8, 32'd8, 32'd0, 1'b0});
    go(1'b1, 1'b0, 8, 8, 8, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({enc_busy, dec_busy, enc_done, dec_done, enc_err, dec_err, fme_start} !== 7'b0) begin
      errors++;
      $display("FAIL rstwait_ctrl got=%b exp=0", {enc_busy, dec_busy, enc_done, dec_done, enc_err, dec_err, fme_start});
    end
    vectors++;
    if ({fme_base, fme_exp, fme_mod, enc_result, dec_result} !== '0) begin
      errors++;
      $display("FAIL rstwait_data ops=%0h/%0h/%0h res=%0h/%0h exp=0", fme_base, fme_exp, fme_mod, enc_result, dec_result);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= enc_done | dec_done | fme_start | enc_busy | enc_err;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_quiet activity=%b exp=0", seen);
    end
    fme_mute = 1'b0;
    q.push_back('{1'b1, 32'd3, 32'd5, 32'd7, 32'd5, 1'b0});
    go(1'b0, 1'b1, 0, 0, 0, 3, 5, 7);
    drain(40, left);
    vectors++;
    if (left !== 0) begin
      errors++;
      $display("FAIL rstwait_fresh pending=%0d exp=0", left);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_busy_ignore();
    test_mod_zero();
    test_timeout();
    test_reset_wait();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
